// File: rtl/uart_tx_arbiter_if.sv
// Handshake bundle between two byte requesters, the arbiter and the UART TX input.
// The arbiter connects through the slave modport; the requesters and TX side use master.
interface uart_tx_arbiter_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] req0_data;
    logic                  req0_valid;
    logic                  req0_last;
    logic                  req0_ready;

    logic [DATA_WIDTH-1:0] req1_data;
    logic                  req1_valid;
    logic                  req1_last;
    logic                  req1_ready;

    logic [DATA_WIDTH-1:0] tx_data;
    logic                  tx_valid;
    logic                  tx_ready;

    logic [1:0]            grant;

    modport slave (
        input  req0_data, req0_valid, req0_last,
        output req0_ready,
        input  req1_data, req1_valid, req1_last,
        output req1_ready,
        output tx_data, tx_valid,
        input  tx_ready,
        output grant
    );

    modport master (
        output req0_data, req0_valid, req0_last,
        input  req0_ready,
        output req1_data, req1_valid, req1_last,
        input  req1_ready,
        input  tx_data, tx_valid,
        output tx_ready,
        input  grant
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Two-requester, round-robin, packet-locked arbiter in front of the UART TX.
// A grant lasts until the owner sends a byte marked last, or until MAX_BURST
// beats have gone by while the other requester is waiting. Every release
// passes through IDLE, so owners are always separated by one bubble cycle.
module uart_tx_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    uart_tx_arbiter_if.slave   bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    // MAX_BURST=0 disables the limit; keep the counter at least one bit wide.
    localparam int CNT_W = (MAX_BURST == 0) ? 1 : $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] BURST_LAST =
        (MAX_BURST == 0) ? '0 : CNT_W'(MAX_BURST - 1);

    state_t                state_q, state_d;
    logic                  last_winner_q, last_winner_d;
    logic [CNT_W-1:0]      beat_cnt_q, beat_cnt_d;
    logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
    logic                  tx_valid_q, tx_valid_d;

    logic                  can_load;
    logic                  ready0, ready1;
    logic                  xfer;
    logic [DATA_WIDTH-1:0] xfer_data;
    logic                  xfer_last;
    logic                  other_valid;
    logic                  burst_end;

    // The output slot can take a byte when it is empty or draining this cycle.
    assign can_load    = !tx_valid_q || bus.tx_ready;
    assign ready0      = (state_q == OWN0) && can_load;
    assign ready1      = (state_q == OWN1) && can_load;
    assign xfer        = (bus.req0_valid && ready0) || (bus.req1_valid && ready1);
    assign xfer_data   = (state_q == OWN1) ? bus.req1_data : bus.req0_data;
    assign xfer_last   = (state_q == OWN1) ? bus.req1_last : bus.req0_last;
    assign other_valid = (state_q == OWN1) ? bus.req0_valid : bus.req1_valid;
    assign burst_end   = (MAX_BURST != 0) && (beat_cnt_q == BURST_LAST);

    assign bus.req0_ready = ready0;
    assign bus.req1_ready = ready1;
    assign bus.tx_data    = tx_data_q;
    assign bus.tx_valid   = tx_valid_q;
    assign bus.grant      = {state_q == OWN1, state_q == OWN0};

    // Grant decision, burst counting and packet-end release.
    always_comb begin
        // NOTE: every always_comb target gets a default first so no path leaves it unassigned (no latch).
        state_d       = state_q;
        last_winner_d = last_winner_q;
        beat_cnt_d    = beat_cnt_q;
        case (state_q)
            IDLE: begin
                if (bus.req0_valid && bus.req1_valid) begin
                    // Tie: serve whoever did not win last time.
                    state_d       = last_winner_q ? OWN0 : OWN1;
                    last_winner_d = !last_winner_q;
                    beat_cnt_d    = '0;
                end else if (bus.req0_valid) begin
                    state_d       = OWN0;
                    last_winner_d = 1'b0;
                    beat_cnt_d    = '0;
                end else if (bus.req1_valid) begin
                    state_d       = OWN1;
                    last_winner_d = 1'b1;
                    beat_cnt_d    = '0;
                end
            end
            OWN0, OWN1: begin
                if (xfer) begin
                    if (xfer_last || (burst_end && other_valid)) begin
                        state_d    = IDLE;
                        beat_cnt_d = '0;
                    end else if (burst_end) begin
                        // Limit hit with nobody waiting: keep the grant, restart the count.
                        beat_cnt_d = '0;
                    end else begin
                        beat_cnt_d = beat_cnt_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output slot: load on a transfer, clear once the UART takes the byte.
    always_comb begin
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        if (xfer) begin
            tx_data_d  = xfer_data;
            tx_valid_d = 1'b1;
        end else if (tx_valid_q && bus.tx_ready) begin
            tx_valid_d = 1'b0;
        end
    end

    // Arbitration state registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: sequential state uses non-blocking (<=) so all registers update together at the edge.
            state_q       <= IDLE;
            last_winner_q <= 1'b1;
            beat_cnt_q    <= '0;
        end else begin
            state_q       <= state_d;
            last_winner_q <= last_winner_d;
            beat_cnt_q    <= beat_cnt_d;
        end
    end

    // Output register towards the UART TX.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
        end else begin
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
        end
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter (MAX_BURST=4): a vector table for
// single-packet and tie-break sequences, plus hand-written multi-cycle cases
// for burst limiting, back-pressure and reset mid-packet.
module tb_uart_tx_arbiter;
    logic clk = 1'b0;
    logic reset_n;

    uart_tx_arbiter_if #(.DATA_WIDTH(8)) bus ();

    uart_tx_arbiter #(
        .DATA_WIDTH(8),
        .MAX_BURST (4)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] obs_q[$];
    logic [7:0] exp_q[$];
    int first0, last0, gaps0;

    // Bytes the UART actually accepts (inputs only change just after posedge).
    always @(negedge clk) begin
        if (reset_n && bus.tx_valid && bus.tx_ready)
            obs_q.push_back(bus.tx_data);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.req0_valid = 1'b0; bus.req0_last = 1'b0; bus.req0_data = 8'h00;
        bus.req1_valid = 1'b0; bus.req1_last = 1'b0; bus.req1_data = 8'h00;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        idle_inputs();
        bus.tx_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic check_stream(input string name);
        check({name, " count"}, obs_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
            check($sformatf("%s byte%0d", name, i), obs_q[i], exp_q[i]);
    endtask

    // Drive two byte streams until both are consumed or the budget expires.
    task automatic run_streams(input int n0, input logic [7:0] b0, input bit last0_flag,
                               input int n1, input logic [7:0] b1, input bit last1_flag,
                               input int budget, input string name);
        int i0 = 0;
        int i1 = 0;
        int c  = 0;
        first0 = -1; last0 = -1; gaps0 = 0;
        while ((i0 < n0 || i1 < n1) && c < budget) begin
            bus.req0_valid = (i0 < n0);
            bus.req0_data  = 8'(int'(b0) + i0);
            bus.req0_last  = last0_flag && (i0 == n0 - 1);
            bus.req1_valid = (i1 < n1);
            bus.req1_data  = 8'(int'(b1) + i1);
            bus.req1_last  = last1_flag && (i1 == n1 - 1);
            @(negedge clk);
            if (first0 >= 0 && bus.grant != 2'b01) gaps0++;
            if (bus.req0_valid && bus.req0_ready) begin
                if (first0 < 0) first0 = c;
                last0 = c;
                i0++;
            end
            if (bus.req1_valid && bus.req1_ready) i1++;
            @(posedge clk);
            #1;
            c++;
        end
        idle_inputs();
        check({name, " completed within budget"}, (i0 == n0 && i1 == n1), 1'b1);
    endtask

    typedef struct {
        logic       rst;
        logic       v0, l0;
        logic [7:0] d0;
        logic       v1, l1;
        logic [7:0] d1;
        logic       txr;
        logic       r0, r1;
        logic [1:0] g;
        logic       tv;
        logic [7:0] td;
    } vec_t;

    vec_t vecs[20];

    initial begin
        reset_n = 1'b0;
        bus.tx_ready = 1'b1;
        idle_inputs();

        // rst | v0 l0 d0 | v1 l1 d1 | txr || r0 r1 grant tv td
        // req0 sends 41,42,43 (last on 43) with tx_ready high.
        vecs[0]  = '{1, 1,0,8'h41, 0,0,8'h00, 1,  0,0,2'b00,0,8'h00};
        vecs[1]  = '{0, 1,0,8'h41, 0,0,8'h00, 1,  1,0,2'b01,0,8'h00};
        vecs[2]  = '{0, 1,0,8'h42, 0,0,8'h00, 1,  1,0,2'b01,1,8'h41};
        vecs[3]  = '{0, 1,1,8'h43, 0,0,8'h00, 1,  1,0,2'b01,1,8'h42};
        vecs[4]  = '{0, 0,0,8'h00, 0,0,8'h00, 1,  0,0,2'b00,1,8'h43};
        vecs[5]  = '{0, 0,0,8'h00, 0,0,8'h00, 1,  0,0,2'b00,0,8'h43};
        // Tie from reset: req0 (10,11) first, bubble, then req1 (20,21).
        vecs[6]  = '{1, 1,0,8'h10, 1,0,8'h20, 1,  0,0,2'b00,0,8'h00};
        vecs[7]  = '{0, 1,0,8'h10, 1,0,8'h20, 1,  1,0,2'b01,0,8'h00};
        vecs[8]  = '{0, 1,1,8'h11, 1,0,8'h20, 1,  1,0,2'b01,1,8'h10};
        vecs[9]  = '{0, 0,0,8'h00, 1,0,8'h20, 1,  0,0,2'b00,1,8'h11};
        vecs[10] = '{0, 0,0,8'h00, 1,0,8'h20, 1,  0,1,2'b10,0,8'h11};
        vecs[11] = '{0, 0,0,8'h00, 1,1,8'h21, 1,  0,1,2'b10,1,8'h20};
        vecs[12] = '{0, 0,0,8'h00, 0,0,8'h00, 1,  0,0,2'b00,1,8'h21};
        // Repeated ties alternate: req0 (after req1 served), then req1, then req0.
        vecs[13] = '{0, 1,1,8'h12, 1,1,8'h22, 1,  0,0,2'b00,0,8'h21};
        vecs[14] = '{0, 1,1,8'h12, 1,1,8'h22, 1,  1,0,2'b01,0,8'h21};
        vecs[15] = '{0, 1,1,8'h13, 1,1,8'h22, 1,  0,0,2'b00,1,8'h12};
        vecs[16] = '{0, 1,1,8'h13, 1,1,8'h22, 1,  0,1,2'b10,0,8'h12};
        vecs[17] = '{0, 1,1,8'h13, 0,0,8'h00, 1,  0,0,2'b00,1,8'h22};
        vecs[18] = '{0, 1,1,8'h13, 0,0,8'h00, 1,  1,0,2'b01,0,8'h22};
        vecs[19] = '{0, 0,0,8'h00, 0,0,8'h00, 1,  0,0,2'b00,1,8'h13};

        for (int i = 0; i < 20; i++) begin
            if (vecs[i].rst) do_reset();
            bus.req0_valid = vecs[i].v0; bus.req0_last = vecs[i].l0; bus.req0_data = vecs[i].d0;
            bus.req1_valid = vecs[i].v1; bus.req1_last = vecs[i].l1; bus.req1_data = vecs[i].d1;
            bus.tx_ready   = vecs[i].txr;
            @(negedge clk);
            check($sformatf("row%0d req0_ready", i), bus.req0_ready, vecs[i].r0);
            check($sformatf("row%0d req1_ready", i), bus.req1_ready, vecs[i].r1);
            check($sformatf("row%0d grant", i),      bus.grant,      vecs[i].g);
            check($sformatf("row%0d tx_valid", i),   bus.tx_valid,   vecs[i].tv);
            check($sformatf("row%0d tx_data", i),    bus.tx_data,    vecs[i].td);
            cyc();
        end

        // Burst limit with req1 waiting: 4 bytes of req0, req1 packet, req0 resumes.
        do_reset();
        obs_q.delete();
        run_streams(10, 8'h60, 1'b0, 2, 8'h30, 1'b1, 60, "burst_wait");
        repeat (3) cyc();
        exp_q = '{8'h60, 8'h61, 8'h62, 8'h63, 8'h30, 8'h31,
                  8'h64, 8'h65, 8'h66, 8'h67, 8'h68, 8'h69};
        check_stream("burst_wait");
        check("burst_wait grant held without last", bus.grant, 2'b01);
        check("burst_wait req1_ready low for non-owner", bus.req1_ready, 1'b0);

        // Burst limit with req1 idle: 10 back-to-back bytes under one grant.
        do_reset();
        obs_q.delete();
        run_streams(10, 8'h70, 1'b0, 0, 8'h00, 1'b0, 40, "burst_alone");
        repeat (3) cyc();
        exp_q = '{8'h70, 8'h71, 8'h72, 8'h73, 8'h74, 8'h75, 8'h76, 8'h77, 8'h78, 8'h79};
        check_stream("burst_alone");
        check("burst_alone span cycles", last0 - first0, 9);
        check("burst_alone grant gaps", gaps0, 0);
        check("burst_alone grant end", bus.grant, 2'b01);

        // Back-pressure: 0x55 held for 5 cycles while tx_ready is low.
        do_reset();
        obs_q.delete();
        bus.req0_valid = 1'b1; bus.req0_data = 8'h54; bus.req0_last = 1'b0;
        cyc();
        cyc();
        bus.req0_data = 8'h55;
        cyc();
        bus.req0_data = 8'h56;
        bus.tx_ready  = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check($sformatf("stall%0d tx_data", k),    bus.tx_data,    8'h55);
            check($sformatf("stall%0d tx_valid", k),   bus.tx_valid,   1'b1);
            check($sformatf("stall%0d req0_ready", k), bus.req0_ready, 1'b0);
            cyc();
        end
        bus.tx_ready = 1'b1;
        @(negedge clk);
        check("stall resume req0_ready", bus.req0_ready, 1'b1);
        cyc();
        bus.req0_data = 8'h57; bus.req0_last = 1'b1;
        cyc();
        idle_inputs();
        repeat (2) cyc();
        exp_q = '{8'h54, 8'h55, 8'h56, 8'h57};
        check_stream("stall");
        check("stall grant after last", bus.grant, 2'b00);

        // Reset mid-packet with a byte held, then a fresh tie goes to req0.
        do_reset();
        bus.req0_valid = 1'b1; bus.req0_data = 8'hA0; bus.req0_last = 1'b0;
        cyc();
        cyc();
        bus.tx_ready  = 1'b0;
        bus.req0_data = 8'hA1;
        #2;
        check("pre-reset tx_valid", bus.tx_valid, 1'b1);
        check("pre-reset grant", bus.grant, 2'b01);
        reset_n = 1'b0;
        #1;
        check("async reset tx_valid", bus.tx_valid, 1'b0);
        check("async reset tx_data", bus.tx_data, 8'h00);
        check("async reset grant", bus.grant, 2'b00);
        check("async reset req0_ready", bus.req0_ready, 1'b0);
        check("async reset req1_ready", bus.req1_ready, 1'b0);
        bus.tx_ready   = 1'b1;
        bus.req0_valid = 1'b1; bus.req0_data = 8'hB0; bus.req0_last = 1'b1;
        bus.req1_valid = 1'b1; bus.req1_data = 8'hB8; bus.req1_last = 1'b1;
        cyc();
        check("in reset grant", bus.grant, 2'b00);
        reset_n = 1'b1;
        obs_q.delete();
        @(negedge clk);
        check("post-reset idle grant", bus.grant, 2'b00);
        cyc();
        @(negedge clk);
        check("post-reset tie grant", bus.grant, 2'b01);
        check("post-reset tie req0_ready", bus.req0_ready, 1'b1);
        check("post-reset tie req1_ready", bus.req1_ready, 1'b0);
        cyc();
        run_streams(0, 8'h00, 1'b0, 1, 8'hB8, 1'b1, 20, "post-reset");
        repeat (3) cyc();
        exp_q = '{8'hB0, 8'hB8};
        check_stream("post-reset");
        check("post-reset drained tx_valid", bus.tx_valid, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
